// File: rtl/csr_timer_bank.sv
// csr_timer_bank
//
// Bank of LoongArch-style countdown timers that sits beside the CPU CSR file
// on the same CSR read/write port. Each channel exposes four CSRs starting at
// CSR_BASE + 4*i: TCFG, TVAL, TICLR, PRESC. A shared 64-bit stable counter
// serves rdcntvl/rdcntvh.
//
// Build option: define TIMER_PRESCALER_EN to compile in the per-channel 8-bit
// prescaler. Without it, PRESC reads 0, ignores writes, and the counters step
// every cycle while enabled.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   csr_re      CSR read enable
//   csr_num     CSR number (14 bits)
//   csr_we      CSR write enable
//   csr_wmask   CSR write mask (1 = take bit from csr_wvalue)
//   csr_wvalue  CSR write data
//   csr_rvalue  combinational read data, 0 when not reading or no match
//   csr_hit     csr_num falls inside this block's CSR window
//   timer_irq   registered per-channel pending bits
//   timer_int   OR of timer_irq
//   stable_cnt  free-running 64-bit counter

module csr_timer_bank #(
  parameter int          NUM_TIMERS = 2,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [13:0] CSR_BASE   = 14'h100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  csr_re,
  input  logic [13:0]           csr_num,
  input  logic                  csr_we,
  input  logic [31:0]           csr_wmask,
  input  logic [31:0]           csr_wvalue,
  output logic [31:0]           csr_rvalue,
  output logic                  csr_hit,
  output logic [NUM_TIMERS-1:0] timer_irq,
  output logic                  timer_int,
  output logic [63:0]           stable_cnt
);

  localparam int                   IW        = CNT_WIDTH - 2;
  localparam logic [13:0]          SPAN      = 14'(4 * NUM_TIMERS);
  localparam logic [1:0]           REG_TCFG  = 2'd0;
  localparam logic [1:0]           REG_TVAL  = 2'd1;
  localparam logic [1:0]           REG_TICLR = 2'd2;
  localparam logic [1:0]           REG_PRESC = 2'd3;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  // Per-channel architectural state
  logic [NUM_TIMERS-1:0] en;
  logic [NUM_TIMERS-1:0] periodic;
  logic [NUM_TIMERS-1:0] pending;
  logic [IW-1:0]         initval [NUM_TIMERS];
  logic [CNT_WIDTH-1:0]  cnt     [NUM_TIMERS];
`ifdef TIMER_PRESCALER_EN
  logic [7:0]            presc   [NUM_TIMERS];
  logic [7:0]            pcnt    [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] wr_presc;
`endif

  // Decode and next-state helpers
  logic [13:0]           csr_off;
  logic [1:0]            reg_sel;
  logic [NUM_TIMERS-1:0] ch_sel;
  logic [NUM_TIMERS-1:0] wr_tcfg;
  logic [NUM_TIMERS-1:0] wr_ticlr;
  logic [NUM_TIMERS-1:0] load;
  logic [NUM_TIMERS-1:0] freeze;
  logic [NUM_TIMERS-1:0] tick;
  logic [NUM_TIMERS-1:0] step;
  logic [NUM_TIMERS-1:0] set_pend;
  logic [31:0]           tcfg_old  [NUM_TIMERS];
  logic [31:0]           tcfg_next [NUM_TIMERS];

  always_comb begin
    csr_off = csr_num - CSR_BASE;
    csr_hit = (csr_num >= CSR_BASE) && (csr_off < SPAN);
    reg_sel = csr_off[1:0];

    for (int i = 0; i < NUM_TIMERS; i++) begin
      ch_sel[i]    = csr_hit && (csr_off[13:2] == 12'(i));
      tcfg_old[i]  = 32'({initval[i], periodic[i], en[i]});
      tcfg_next[i] = (csr_wmask & csr_wvalue) | (~csr_wmask & tcfg_old[i]);
      wr_tcfg[i]   = csr_we && ch_sel[i] && (reg_sel == REG_TCFG);
      wr_ticlr[i]  = csr_we && ch_sel[i] && (reg_sel == REG_TICLR)
                     && csr_wmask[0] && csr_wvalue[0];
      // A TCFG write leaving EN=1 always reloads; one leaving EN=0 holds the
      // counter exactly where it is, so it must also block this edge's step.
      load[i]      = wr_tcfg[i] && tcfg_next[i][0];
      freeze[i]    = wr_tcfg[i] && !tcfg_next[i][0];
`ifdef TIMER_PRESCALER_EN
      wr_presc[i]  = csr_we && ch_sel[i] && (reg_sel == REG_PRESC);
      tick[i]      = (pcnt[i] == presc[i]);
`else
      tick[i]      = 1'b1;
`endif
      step[i]      = tick[i] && en[i] && !freeze[i];
      set_pend[i]  = step[i] && (cnt[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_cnt <= '0;
      en         <= '0;
      periodic   <= '0;
      pending    <= '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        initval[i] <= '0;
        cnt[i]     <= '1;
`ifdef TIMER_PRESCALER_EN
        presc[i]   <= '0;
        pcnt[i]    <= '0;
`endif
      end
    end else begin
      stable_cnt <= stable_cnt + 64'd1;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (wr_tcfg[i]) begin
          en[i]       <= tcfg_next[i][0];
          periodic[i] <= tcfg_next[i][1];
          initval[i]  <= tcfg_next[i][CNT_WIDTH-1:2];
        end

        // all-ones is the halted state of a one-shot channel
        if (load[i]) begin
          cnt[i] <= {tcfg_next[i][CNT_WIDTH-1:2], 2'b00};
        end else if (step[i] && (cnt[i] != '1)) begin
          if ((cnt[i] == '0) && periodic[i]) begin
            cnt[i] <= {initval[i], 2'b00};
          end else begin
            cnt[i] <= cnt[i] - CNT_ONE;
          end
        end

        // A set in the same cycle as a TICLR clear wins
        if (set_pend[i]) begin
          pending[i] <= 1'b1;
        end else if (wr_ticlr[i]) begin
          pending[i] <= 1'b0;
        end

`ifdef TIMER_PRESCALER_EN
        if (wr_presc[i]) begin
          presc[i] <= (csr_wmask[7:0] & csr_wvalue[7:0])
                      | (~csr_wmask[7:0] & presc[i]);
        end
        if (load[i]) begin
          pcnt[i] <= '0;
        end else if (en[i] && !freeze[i]) begin
          pcnt[i] <= (pcnt[i] == presc[i]) ? 8'd0 : pcnt[i] + 8'd1;
        end
`endif
      end
    end
  end

  always_comb begin
    csr_rvalue = '0;
    if (csr_re) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (ch_sel[i]) begin
          case (reg_sel)
            REG_TCFG:  csr_rvalue = tcfg_old[i];
            REG_TVAL:  csr_rvalue = 32'(cnt[i]);
`ifdef TIMER_PRESCALER_EN
            REG_PRESC: csr_rvalue = 32'(presc[i]);
`else
            REG_PRESC: csr_rvalue = '0;
`endif
            default:   csr_rvalue = '0;
          endcase
        end
      end
    end
  end

  assign timer_irq = pending;
  assign timer_int = |pending;

endmodule

// File: tb/tb_csr_timer_bank.sv
module tb_csr_timer_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_re = 1'b0;
  logic [13:0] csr_num = 14'h0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wmask = 32'h0;
  logic [31:0] csr_wvalue = 32'h0;
  logic [31:0] csr_rvalue;
  logic        csr_hit;
  logic [1:0]  timer_irq;
  logic        timer_int;
  logic [63:0] stable_cnt;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_stable;

  csr_timer_bank #(.NUM_TIMERS(2), .CNT_WIDTH(32), .CSR_BASE(14'h100)) dut (
    .clk(clk), .reset(reset), .csr_re(csr_re), .csr_num(csr_num),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .csr_rvalue(csr_rvalue), .csr_hit(csr_hit), .timer_irq(timer_irq),
    .timer_int(timer_int), .stable_cnt(stable_cnt)
  );

  always #5 clk = ~clk;

  // reference cycle count for the stable counter
  always @(posedge clk) begin
    if (reset) exp_stable <= 64'd0;
    else       exp_stable <= exp_stable + 64'd1;
  end

  task automatic wr(input logic [13:0] num, input logic [31:0] m, input logic [31:0] v);
    csr_num = num; csr_wmask = m; csr_wvalue = v; csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0; csr_wmask = 32'h0; csr_wvalue = 32'h0;
  endtask

  task automatic rd(input logic [13:0] num, output logic [31:0] d, output logic h);
    csr_re = 1'b1; csr_num = num;
    #1;
    d = csr_rvalue; h = csr_hit;
    csr_re = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d; logic h;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (stable_cnt !== 64'd0) begin errors++; $display("FAIL reset_stable0 got %0d want 0", stable_cnt); end
    rd(14'h101, d, h);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_tval0 got %h want ffffffff", d); end
    rd(14'h105, d, h);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_tval1 got %h want ffffffff", d); end
    rd(14'h100, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b1) begin errors++; $display("FAIL reset_tcfg0 got %h hit %b want 0 hit 1", d, h); end
    rd(14'h104, d, h);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_tcfg1 got %h want 0", d); end
    checks++; if (timer_irq !== 2'b00 || timer_int !== 1'b0) begin errors++; $display("FAIL reset_irq got %b/%b want 00/0", timer_irq, timer_int); end
    @(negedge clk);
    checks++; if (stable_cnt !== 64'd1) begin errors++; $display("FAIL stable_1 got %0d want 1", stable_cnt); end
    @(negedge clk);
    checks++; if (stable_cnt !== 64'd2) begin errors++; $display("FAIL stable_2 got %0d want 2", stable_cnt); end
  endtask

  task automatic test_oneshot;
    logic [31:0] d; logic h;
    @(negedge clk);
    // same-cycle read returns old TCFG
    csr_num = 14'h100; csr_wmask = 32'hFFFFFFFF; csr_wvalue = 32'hD; csr_we = 1'b1; csr_re = 1'b1;
    #1;
    checks++; if (csr_rvalue !== 32'h0) begin errors++; $display("FAIL same_cycle_read got %h want 0", csr_rvalue); end
    @(negedge clk);
    csr_we = 1'b0; csr_re = 1'b0;
    for (int k = 12; k >= 0; k--) begin
      if (k != 12) @(negedge clk);
      rd(14'h101, d, h);
      checks++; if (d !== 32'(k)) begin errors++; $display("FAIL oneshot_tval got %0d want %0d", d, k); end
      checks++; if (timer_irq[0] !== 1'b0) begin errors++; $display("FAIL oneshot_early_irq at tval %0d got %b want 0", k, timer_irq[0]); end
    end
    @(negedge clk);
    rd(14'h101, d, h);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL oneshot_wrap got %h want ffffffff", d); end
    checks++; if (timer_irq[0] !== 1'b1) begin errors++; $display("FAIL oneshot_irq got %b want 1", timer_irq[0]); end
    repeat (3) @(negedge clk);
    rd(14'h101, d, h);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL oneshot_halt got %h want ffffffff", d); end
    checks++; if (timer_irq !== 2'b01 || timer_int !== 1'b1) begin errors++; $display("FAIL oneshot_hold got %b/%b want 01/1", timer_irq, timer_int); end
    wr(14'h100, 32'hFFFFFFFF, 32'h0);
    wr(14'h102, 32'h1, 32'h1);
    checks++; if (timer_irq !== 2'b00 || timer_int !== 1'b0) begin errors++; $display("FAIL ticlr0 got %b/%b want 00/0", timer_irq, timer_int); end
    rd(14'h102, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b1) begin errors++; $display("FAIL ticlr_read got %h hit %b want 0 hit 1", d, h); end
    checks++; if (stable_cnt !== exp_stable) begin errors++; $display("FAIL stable_track got %0d want %0d", stable_cnt, exp_stable); end
  endtask

  task automatic test_periodic;
    logic [31:0] d; logic h;
    wr(14'h104, 32'hFFFFFFFF, 32'h7);
    rd(14'h105, d, h);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL per_load got %0d want 4", d); end
    for (int k = 3; k >= 0; k--) begin
      @(negedge clk);
      rd(14'h105, d, h);
      checks++; if (d !== 32'(k) || timer_irq[1] !== 1'b0) begin errors++; $display("FAIL per_count got %0d irq %b want %0d irq 0", d, timer_irq[1], k); end
    end
    @(negedge clk);
    rd(14'h105, d, h);
    checks++; if (d !== 32'd4 || timer_irq[1] !== 1'b1) begin errors++; $display("FAIL per_reload got %0d irq %b want 4 irq 1", d, timer_irq[1]); end
    wr(14'h106, 32'h1, 32'h1);
    rd(14'h105, d, h);
    checks++; if (d !== 32'd3 || timer_irq[1] !== 1'b0) begin errors++; $display("FAIL per_clear got %0d irq %b want 3 irq 0", d, timer_irq[1]); end
    repeat (3) @(negedge clk);
    rd(14'h105, d, h);
    checks++; if (d !== 32'd0 || timer_irq[1] !== 1'b0) begin errors++; $display("FAIL per_zero got %0d irq %b want 0 irq 0", d, timer_irq[1]); end
    @(negedge clk);
    rd(14'h105, d, h);
    checks++; if (d !== 32'd4 || timer_irq[1] !== 1'b1) begin errors++; $display("FAIL per_period5 got %0d irq %b want 4 irq 1", d, timer_irq[1]); end
    wr(14'h106, 32'h1, 32'h1);
    checks++; if (timer_irq[1] !== 1'b0) begin errors++; $display("FAIL per_clear2 got %b want 0", timer_irq[1]); end
    repeat (3) @(negedge clk);
    rd(14'h105, d, h);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL per_pre_collide got %0d want 0", d); end
    wr(14'h106, 32'h1, 32'h1);
    checks++; if (timer_irq !== 2'b10) begin errors++; $display("FAIL set_beats_clear got %b want 10", timer_irq); end
  endtask

  task automatic test_mask_freeze;
    logic [31:0] d; logic h;
    rd(14'h105, d, h);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL freeze_pre got %0d want 4", d); end
    wr(14'h104, 32'h1, 32'h0);
    rd(14'h105, d, h);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL freeze_now got %0d want 4", d); end
    rd(14'h104, d, h);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL freeze_tcfg got %h want 6", d); end
    repeat (4) @(negedge clk);
    rd(14'h105, d, h);
    checks++; if (d !== 32'd4 || timer_irq[1] !== 1'b1) begin errors++; $display("FAIL freeze_hold got %0d irq %b want 4 irq 1", d, timer_irq[1]); end
  endtask

  task automatic test_independent;
    logic [31:0] d; logic h;
    wr(14'h100, 32'hFFFFFFFF, 32'h5);
    wr(14'h104, 32'h1, 32'h1);
    rd(14'h104, d, h);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL indep_tcfg1 got %h want 7", d); end
    repeat (5) @(negedge clk);
    checks++; if (timer_irq !== 2'b11) begin errors++; $display("FAIL indep_both got %b want 11", timer_irq); end
    wr(14'h106, 32'h1, 32'h1);
    checks++; if (timer_irq !== 2'b01 || timer_int !== 1'b1) begin errors++; $display("FAIL indep_clear1 got %b/%b want 01/1", timer_irq, timer_int); end
    rd(14'h101, d, h);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL indep_tval0 got %h want ffffffff", d); end
    rd(14'h105, d, h);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL indep_tval1 got %0d want 3", d); end
  endtask

  task automatic test_unmapped;
    logic [31:0] d; logic h;
    rd(14'h108, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b0) begin errors++; $display("FAIL unmapped_hi got %h hit %b want 0 hit 0", d, h); end
    rd(14'h0FF, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b0) begin errors++; $display("FAIL unmapped_lo got %h hit %b want 0 hit 0", d, h); end
    csr_num = 14'h104; csr_re = 1'b0;
    #1;
    checks++; if (csr_rvalue !== 32'h0 || csr_hit !== 1'b1) begin errors++; $display("FAIL no_re got %h hit %b want 0 hit 1", csr_rvalue, csr_hit); end
  endtask

  task automatic test_presc;
    logic [31:0] d; logic h;
    @(negedge clk);
`ifdef TIMER_PRESCALER_EN
    wr(14'h103, 32'hFFFFFFFF, 32'h3);
    rd(14'h103, d, h);
    checks++; if (d !== 32'h3 || h !== 1'b1) begin errors++; $display("FAIL presc_rb got %h hit %b want 3 hit 1", d, h); end
    wr(14'h100, 32'hFFFFFFFF, 32'h5);
    for (int c = 0; c <= 8; c++) begin
      if (c != 0) @(negedge clk);
      rd(14'h101, d, h);
      checks++; if (d !== 32'(4 - c / 4)) begin errors++; $display("FAIL presc_cnt cycle %0d got %0d want %0d", c, d, 4 - c / 4); end
    end
`else
    wr(14'h103, 32'hFFFFFFFF, 32'h3);
    rd(14'h103, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b1) begin errors++; $display("FAIL presc_off got %h hit %b want 0 hit 1", d, h); end
`endif
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; logic h;
    wr(14'h100, 32'hFFFFFFFF, 32'hD);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    csr_num = 14'h104; csr_wmask = 32'hFFFFFFFF; csr_wvalue = 32'h5; csr_we = 1'b1;
    @(negedge clk);
    reset = 1'b0; csr_we = 1'b0;
    rd(14'h100, d, h);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_tcfg0 got %h want 0", d); end
    rd(14'h104, d, h);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_prio_tcfg1 got %h want 0", d); end
    rd(14'h101, d, h);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL rst_tval0 got %h want ffffffff", d); end
    checks++; if (timer_irq !== 2'b00 || timer_int !== 1'b0 || stable_cnt !== 64'd0) begin errors++; $display("FAIL rst_mid got irq %b int %b stable %0d want 00 0 0", timer_irq, timer_int, stable_cnt); end
    @(negedge clk);
    rd(14'h105, d, h);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL rst_idle_tval1 got %h want ffffffff", d); end
    checks++; if (stable_cnt !== 64'd1) begin errors++; $display("FAIL rst_stable got %0d want 1", stable_cnt); end
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_periodic;
    test_mask_freeze;
    test_independent;
    test_unmapped;
    test_presc;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
